// File: rtl/calc_seq_ctrl_if.sv
// Bus between the calculator sequencer and its surroundings.
// The switch/button inputs, the operand register read-back, the operand load
// path and the result/status outputs travel together on this interface.
//   master : switches, buttons and operand registers (drive inputs, observe outputs)
//   slave  : calc_seq_ctrl
// Signals:
//   sw_data[3:0]  operand value from switches
//   op_sel[1:0]   operator: 00 add, 01 sub, 10 mul, 11 div
//   enter         single-cycle advance pulse
//   clear         abort back to operand A entry
//   a_q/b_q[3:0]  current reg_A / reg_B contents
//   load_a/load_b one-cycle load strobes to reg_A / reg_B
//   reg_d[3:0]    data to reg_A / reg_B
//   result[7:0]   operation result
//   result_valid  result is final (DONE)
//   err           divide-by-zero
//   busy          loading an operand or executing
//   state[2:0]    current sequencer state encoding
interface calc_seq_ctrl_if;
    logic [3:0] sw_data;
    logic [1:0] op_sel;
    logic       enter;
    logic       clear;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       load_a;
    logic       load_b;
    logic [3:0] reg_d;
    logic [7:0] result;
    logic       result_valid;
    logic       err;
    logic       busy;
    logic [2:0] state;

    modport master (
        output sw_data, op_sel, enter, clear, a_q, b_q,
        input  load_a, load_b, reg_d, result, result_valid, err, busy, state
    );

    modport slave (
        input  sw_data, op_sel, enter, clear, a_q, b_q,
        output load_a, load_b, reg_d, result, result_valid, err, busy, state
    );
endinterface

// File: rtl/calc_seq_ctrl.sv
// Sequencing controller for the 4-bit calculator: operand A entry, operand B
// entry, operator entry, then execution of add/sub (1 cycle) or mul/div
// (4 cycles, one bit per cycle). Every output is registered.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset, highest priority
//   bus    calc_seq_ctrl_if.slave (switches, operand registers, result/status)
//
// state   | meaning
// --------+-------------------------------------------------
// WAIT_A  | waiting for enter with operand A on the switches
// LOAD_A  | load_a strobe high, reg_A captures reg_d
// WAIT_B  | waiting for enter with operand B on the switches
// LOAD_B  | load_b strobe high, reg_B captures reg_d
// WAIT_OP | waiting for enter with the operator selected
// EXEC    | operation running (1 or 4 cycles)
// DONE    | result valid, enter returns to WAIT_A
module calc_seq_ctrl (
    input  logic           clk,
    input  logic           reset,
    calc_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        LOAD_A  = 3'd1,
        WAIT_B  = 3'd2,
        LOAD_B  = 3'd3,
        WAIT_OP = 3'd4,
        EXEC    = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    state_t     state_q, state_next;
    logic [1:0] op_q, op_next;
    logic [1:0] cnt_q, cnt_next;
    logic [7:0] acc_q, acc_next;
    logic [3:0] reg_d_q, reg_d_next;
    logic [7:0] result_q, result_next;
    logic       err_q, err_next;
    logic       load_a_q, load_a_next;
    logic       load_b_q, load_b_next;
    logic       valid_q, valid_next;
    logic       busy_q, busy_next;

    // One shift-add step: add a_q shifted by the current multiplier bit index.
    logic [7:0] mul_acc;
    // One restoring-division step; acc holds {remainder, quotient}.
    logic [4:0] rem_shift;
    logic [4:0] rem_sub;
    logic       rem_ge;
    logic [7:0] div_acc;
    logic [4:0] sum5;
    logic [7:0] diff8;

    always_comb begin
        mul_acc   = acc_q + (bus.b_q[cnt_q] ? ({4'b0, bus.a_q} << cnt_q) : 8'd0);
        rem_shift = {acc_q[7:4], bus.a_q[2'd3 - cnt_q]};
        rem_sub   = rem_shift - {1'b0, bus.b_q};
        rem_ge    = (rem_shift >= {1'b0, bus.b_q});
        div_acc   = {(rem_ge ? rem_sub[3:0] : rem_shift[3:0]), acc_q[2:0], rem_ge};
        sum5      = {1'b0, bus.a_q} + {1'b0, bus.b_q};
        diff8     = {4'b0, bus.a_q} - {4'b0, bus.b_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WAIT_A;
            op_q     <= 2'd0;
            cnt_q    <= 2'd0;
            acc_q    <= 8'd0;
            reg_d_q  <= 4'd0;
            result_q <= 8'd0;
            err_q    <= 1'b0;
            load_a_q <= 1'b0;
            load_b_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_next;
            op_q     <= op_next;
            cnt_q    <= cnt_next;
            acc_q    <= acc_next;
            reg_d_q  <= reg_d_next;
            result_q <= result_next;
            err_q    <= err_next;
            load_a_q <= load_a_next;
            load_b_q <= load_b_next;
            valid_q  <= valid_next;
            busy_q   <= busy_next;
        end
    end

    always_comb begin
        state_next  = state_q;
        op_next     = op_q;
        cnt_next    = cnt_q;
        acc_next    = acc_q;
        reg_d_next  = reg_d_q;
        result_next = result_q;
        err_next    = err_q;

        if (bus.clear) begin
            // Abort drops any partial work; result is wiped, reg_d is left alone.
            state_next  = WAIT_A;
            cnt_next    = 2'd0;
            acc_next    = 8'd0;
            result_next = 8'd0;
            err_next    = 1'b0;
        end else begin
            case (state_q)
                WAIT_A: begin
                    if (bus.enter) begin
                        reg_d_next = bus.sw_data;
                        state_next = LOAD_A;
                    end
                end
                LOAD_A: state_next = WAIT_B;
                WAIT_B: begin
                    if (bus.enter) begin
                        reg_d_next = bus.sw_data;
                        state_next = LOAD_B;
                    end
                end
                LOAD_B: state_next = WAIT_OP;
                WAIT_OP: begin
                    if (bus.enter) begin
                        op_next    = bus.op_sel;
                        cnt_next   = 2'd0;
                        acc_next   = 8'd0;
                        err_next   = 1'b0;
                        state_next = EXEC;
                    end
                end
                EXEC: begin
                    case (op_q)
                        OP_ADD: begin
                            result_next = {3'b0, sum5};
                            state_next  = DONE;
                        end
                        OP_SUB: begin
                            result_next = diff8;
                            state_next  = DONE;
                        end
                        OP_MUL: begin
                            acc_next = mul_acc;
                            cnt_next = cnt_q + 2'd1;
                            if (cnt_q == 2'd3) begin
                                result_next = mul_acc;
                                state_next  = DONE;
                            end
                        end
                        OP_DIV: begin
                            if (bus.b_q == 4'd0) begin
                                result_next = 8'hFF;
                                err_next    = 1'b1;
                                state_next  = DONE;
                            end else begin
                                acc_next = div_acc;
                                cnt_next = cnt_q + 2'd1;
                                if (cnt_q == 2'd3) begin
                                    result_next = div_acc;
                                    state_next  = DONE;
                                end
                            end
                        end
                    endcase
                end
                DONE: begin
                    if (bus.enter) begin
                        err_next   = 1'b0;
                        state_next = WAIT_A;
                    end
                end
                default: state_next = WAIT_A;
            endcase
        end

        // Status flags are registered versions of the state being entered.
        load_a_next = (state_next == LOAD_A);
        load_b_next = (state_next == LOAD_B);
        valid_next  = (state_next == DONE);
        busy_next   = (state_next == LOAD_A) || (state_next == LOAD_B) ||
                      (state_next == EXEC);
    end

    assign bus.load_a       = load_a_q;
    assign bus.load_b       = load_b_q;
    assign bus.reg_d        = reg_d_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.err          = err_q;
    assign bus.busy         = busy_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: table of directed calculations,
// randomized calculations against an arithmetic reference model, and
// hand-written abort/priority/ignored-pulse sequences. reg_A/reg_B are
// modelled here as plain 4-bit registers loaded by the strobes.
module tb_calc_seq_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    calc_seq_ctrl_if bus ();

    calc_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.a_q <= 4'd0;
            bus.b_q <= 4'd0;
        end else begin
            if (bus.load_a) bus.a_q <= bus.reg_d;
            if (bus.load_b) bus.b_q <= bus.reg_d;
        end
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [7:0] exp_res;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference: result straight from the arithmetic definition of each operator.
    function automatic void model(input int a, input int b, input int op,
                                  output int res, output int e, output int lat);
        e = 0;
        case (op)
            0: begin res = a + b; lat = 2; end
            1: begin res = (a - b) & 255; lat = 2; end
            2: begin res = a * b; lat = 5; end
            default: begin
                if (b == 0) begin res = 255; e = 1; lat = 2; end
                else begin res = ((a % b) << 4) | (a / b); lat = 5; end
            end
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.sw_data = 4'($urandom);
            step();
        end
    endtask

    // Enter A and B; leaves the controller in WAIT_OP.
    task automatic load_ops(input logic [3:0] a, input logic [3:0] b,
                            input bit noisy, input int gap);
        bus.sw_data = a; bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        chk("load_a_pulse", bus.load_a, 1);
        chk("reg_d_a", bus.reg_d, a);
        chk("state_load_a", bus.state, 1);
        chk("busy_load_a", bus.busy, 1);
        if (noisy) begin
            bus.enter = 1'b1; bus.sw_data = ~a;
        end
        step();
        bus.enter = 1'b0;
        chk("state_wait_b", bus.state, 2);
        chk("load_a_drop", bus.load_a, 0);
        chk("reg_d_hold", bus.reg_d, a);
        chk("a_q", bus.a_q, a);
        idle(gap);
        bus.sw_data = b; bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        chk("load_b_pulse", bus.load_b, 1);
        chk("reg_d_b", bus.reg_d, b);
        chk("state_load_b", bus.state, 3);
        step();
        chk("state_wait_op", bus.state, 4);
        chk("b_q", bus.b_q, b);
        idle(gap);
    endtask

    task automatic run_calc(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                            input int er, input int ee, input int el,
                            input bit noisy, input int gap);
        int lat;
        int busy_cnt;
        load_ops(a, b, noisy, gap);
        bus.op_sel = op; bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        bus.op_sel = 2'($urandom);
        chk("state_exec", bus.state, 5);
        lat = 1;
        busy_cnt = 0;
        while (!bus.result_valid && lat < 12) begin
            busy_cnt += int'(bus.busy);
            bus.enter = noisy && (lat == 1);
            step();
            bus.enter = 1'b0;
            lat++;
        end
        chk("latency", lat, el);
        chk("busy_cycles", busy_cnt, el - 1);
        chk("result", bus.result, er);
        chk("err", bus.err, ee);
        chk("state_done", bus.state, 6);
        chk("busy_done", bus.busy, 0);
        step();
        chk("result_hold", bus.result, er);
        chk("valid_hold", bus.result_valid, 1);
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        chk("state_after_done", bus.state, 0);
        chk("valid_drop", bus.result_valid, 0);
        chk("err_drop", bus.err, 0);
        chk("result_kept", bus.result, er);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int res, e, lat;
        bit seen;
        logic [3:0] ra, rb;
        logic [1:0] rop;

        vecs[0]  = '{4'd9,  4'd7,  2'b00, 8'h10, 1'b0, 2};
        vecs[1]  = '{4'd3,  4'd5,  2'b01, 8'hFE, 1'b0, 2};
        vecs[2]  = '{4'd15, 4'd15, 2'b10, 8'hE1, 1'b0, 5};
        vecs[3]  = '{4'd13, 4'd4,  2'b11, 8'h13, 1'b0, 5};
        vecs[4]  = '{4'd13, 4'd0,  2'b11, 8'hFF, 1'b1, 2};
        vecs[5]  = '{4'd15, 4'd15, 2'b00, 8'h1E, 1'b0, 2};
        vecs[6]  = '{4'd0,  4'd15, 2'b01, 8'hF1, 1'b0, 2};
        vecs[7]  = '{4'd7,  4'd0,  2'b10, 8'h00, 1'b0, 5};
        vecs[8]  = '{4'd15, 4'd1,  2'b11, 8'h0F, 1'b0, 5};
        vecs[9]  = '{4'd2,  4'd15, 2'b11, 8'h20, 1'b0, 5};
        vecs[10] = '{4'd6,  4'd6,  2'b01, 8'h00, 1'b0, 2};

        bus.sw_data = 4'd0; bus.op_sel = 2'd0; bus.enter = 1'b0; bus.clear = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_state", bus.state, 0);
        chk("rst_load_a", bus.load_a, 0);
        chk("rst_load_b", bus.load_b, 0);
        chk("rst_reg_d", bus.reg_d, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_valid", bus.result_valid, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_busy", bus.busy, 0);

        foreach (vecs[i])
            run_calc(vecs[i].a, vecs[i].b, vecs[i].op, int'(vecs[i].exp_res),
                     int'(vecs[i].exp_err), vecs[i].exp_lat, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            ra  = 4'($urandom);
            rb  = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
            rop = 2'($urandom);
            model(int'(ra), int'(rb), int'(rop), res, e, lat);
            run_calc(ra, rb, rop, res, e, lat, 1'($urandom), int'($urandom_range(0, 2)));
        end

        // Extra enter pulses in LOAD_A and EXEC must not disturb a multiply.
        run_calc(4'd11, 4'd13, 2'b10, 143, 0, 5, 1'b1, 1);

        // clear on the second EXEC cycle of a multiply.
        run_calc(4'd9, 4'd7, 2'b00, 16, 0, 2, 1'b0, 0);
        load_ops(4'd15, 4'd15, 1'b0, 0);
        bus.op_sel = 2'b10; bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        step();
        chk("mul_still_exec", bus.state, 5);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("clr_state", bus.state, 0);
        chk("clr_result", bus.result, 0);
        chk("clr_valid", bus.result_valid, 0);
        chk("clr_busy", bus.busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.result_valid) seen = 1'b1;
        end
        chk("clr_no_valid", int'(seen), 0);
        chk("clr_state_stays", bus.state, 0);

        // enter together with clear in WAIT_B.
        bus.sw_data = 4'd5; bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        step();
        chk("pre_wait_b", bus.state, 2);
        bus.sw_data = 4'd6; bus.enter = 1'b1; bus.clear = 1'b1;
        step();
        bus.enter = 1'b0; bus.clear = 1'b0;
        chk("clr_enter_state", bus.state, 0);
        chk("clr_enter_load_b", bus.load_b, 0);
        chk("clr_enter_reg_d", bus.reg_d, 5);

        // reset together with clear, from mid-sequence.
        bus.sw_data = 4'd12; bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        reset = 1'b1; bus.clear = 1'b1;
        step();
        reset = 1'b0; bus.clear = 1'b0;
        chk("rc_state", bus.state, 0);
        chk("rc_load_a", bus.load_a, 0);
        chk("rc_reg_d", bus.reg_d, 0);
        chk("rc_result", bus.result, 0);
        chk("rc_valid", bus.result_valid, 0);
        chk("rc_err", bus.err, 0);
        chk("rc_busy", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
